// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with a start/busy/done handshake.
// Build option MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int  DATA_WIDTH = 32,
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] src_a_i,
    input  logic [DATA_WIDTH-1:0] src_b_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ONES    = {DATA_WIDTH{1'b1}};

    logic [1:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [2:0]            r_funct3;
    logic                  r_neg;
    logic                  r_special;
    // Multiply: {r_acc, r_lo} is the product register, r_lo starts as |b|, r_opnd is |a|.
    // Divide: r_acc is the partial remainder, r_lo dividend/quotient, r_opnd the divisor.
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [DATA_WIDTH-1:0] r_opnd;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
    logic                  w_b_zero, w_ovf, w_special, w_neg_res;
    logic [DATA_WIDTH-1:0] w_abs_a, w_abs_b, w_spec_val;

    always_comb begin
        w_is_div   = funct3_i[2];
        w_sgn_a    = w_is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
        w_sgn_b    = w_is_div ? ~funct3_i[0] : ~funct3_i[1];
        w_neg_a    = w_sgn_a & src_a_i[DATA_WIDTH-1];
        w_neg_b    = w_sgn_b & src_b_i[DATA_WIDTH-1];
        w_abs_a    = w_neg_a ? -src_a_i : src_a_i;
        w_abs_b    = w_neg_b ? -src_b_i : src_b_i;
        w_b_zero   = (src_b_i == '0);
        w_ovf      = ~funct3_i[0] & (src_a_i == MIN_NEG) & (src_b_i == ONES);
        w_special  = w_is_div & (w_b_zero | w_ovf);
        w_spec_val = w_b_zero ? (funct3_i[1] ? src_a_i : ONES)
                              : (funct3_i[1] ? '0 : MIN_NEG);
        // Remainder follows the dividend sign; everything else follows the sign product.
        w_neg_res  = (w_is_div & funct3_i[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
    end

    logic [DATA_WIDTH:0]   w_sum, w_shift;
    logic [DATA_WIDTH-1:0] w_diff, w_acc_nxt, w_lo_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_m1;
    logic                  w_ge, w_calc_exit;

    always_comb begin
        w_sum    = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_shift  = {r_acc, r_lo[DATA_WIDTH-1]};
        w_ge     = (w_shift >= {1'b0, r_opnd});
        w_diff   = w_shift[DATA_WIDTH-1:0] - r_opnd;
        w_cnt_m1 = r_cnt - CNT_WIDTH'(1);
        if (r_funct3[2]) begin
            w_acc_nxt = w_ge ? w_diff : w_shift[DATA_WIDTH-1:0];
            w_lo_nxt  = {r_lo[DATA_WIDTH-2:0], w_ge};
        end else begin
            w_acc_nxt = w_sum[DATA_WIDTH:1];
            w_lo_nxt  = {w_sum[0], r_lo[DATA_WIDTH-1:1]};
        end
`ifdef MULDIV_EARLY_OUT_EN
        // The low r_cnt-1 bits of the next r_lo are the multiplier bits still to be consumed.
        w_calc_exit = (r_cnt == CNT_WIDTH'(1)) |
                      (~r_funct3[2] & ((w_lo_nxt & ~(ONES << w_cnt_m1)) == '0));
`else
        w_calc_exit = (r_cnt == CNT_WIDTH'(1));
`endif
    end

    logic [2*DATA_WIDTH-1:0] w_prod, w_prod_s;
    logic [DATA_WIDTH-1:0]   w_dv, w_dv_s, w_fix_res;

    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        w_prod = {r_acc, r_lo} >> r_cnt;
`else
        w_prod = {r_acc, r_lo};
`endif
        w_prod_s = r_neg ? -w_prod : w_prod;
        w_dv     = r_funct3[1] ? r_acc : r_lo;
        w_dv_s   = r_neg ? -w_dv : w_dv;
        if (r_special)
            w_fix_res = r_lo;
        else if (r_funct3[2])
            w_fix_res = w_dv_s;
        else if (r_funct3[1:0] == 2'b00)
            w_fix_res = w_prod_s[DATA_WIDTH-1:0];
        else
            w_fix_res = w_prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_neg     <= 1'b0;
            r_special <= 1'b0;
            r_acc     <= '0;
            r_lo      <= '0;
            r_opnd    <= '0;
            r_result  <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_funct3  <= funct3_i;
                        r_neg     <= w_neg_res;
                        r_special <= w_special;
                        r_acc     <= '0;
                        r_lo      <= w_special ? w_spec_val : (w_is_div ? w_abs_a : w_abs_b);
                        r_opnd    <= w_is_div ? w_abs_b : w_abs_a;
                        r_cnt     <= w_special ? '0 : CNT_WIDTH'(DATA_WIDTH);
                        r_state   <= w_special ? S_FIX : S_CALC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= w_cnt_m1;
                    if (w_calc_exit) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = (r_state == S_CALC) || (r_state == S_FIX);
    assign done_o   = (r_state == S_DONE);
    assign result_o = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized scoreboard bench for muldiv_unit (DATA_WIDTH = 32).
module tb_muldiv_unit;
    logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, flush_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] src_a_i = '0, src_b_i = '0;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int MUL_LAT   = -34;  // negative: upper bound only
    localparam int EARLY_LAT = -3;
`else
    localparam int MUL_LAT   = 34;
    localparam int EARLY_LAT = 34;
`endif

    int          n_cmp = 0, n_err = 0;
    logic [31:0] q_res[$];
    int          q_lat[$];
    logic [31:0] last_res = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ubs, p;
        logic [63:0]        up;
        sa = $signed(a); sb = $signed(b); ubs = $signed({32'b0, b});
        up = {32'b0, a} * {32'b0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ubs; return p[63:32]; end
            3'd3: return up[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a
                         : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0
                         : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
        return f3[2] ? 34 : MUL_LAT;
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        q_res.push_back(exp); q_lat.push_back(lat);
        @(posedge clk); #1;
        start_i = 1'b1; funct3_i = f3; src_a_i = a; src_b_i = b;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // Counts cycles after the start edge until done_o, then scores against the queue head.
    task automatic wait_done(input string tag, input bit poke, input bit chain,
                             input logic [2:0] nf3, input logic [31:0] na, input logic [31:0] nb);
        int n = 0, nbusy = 0, el;
        bit got = 1'b0;
        logic [31:0] er;
        while (!got && n < 200) begin
            @(negedge clk); n++;
            if (done_o) got = 1'b1;
            else if (busy_o) nbusy++;
            if (poke && n == 5) begin start_i = 1'b1; funct3_i = 3'd0; src_a_i = 32'hDEAD_BEEF; src_b_i = 32'd5; end
            if (poke && n == 6) start_i = 1'b0;
        end
        er = q_res.pop_front(); el = q_lat.pop_front();
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_res"}, result_o, er);
        if (el > 0) begin
            check({tag, "_lat"}, n, el);
            check({tag, "_busy"}, nbusy, el - 1);
        end else begin
            check({tag, "_lat_max"}, 32'(n <= -el), 32'd1);
        end
        last_res = er;
        if (chain) begin
            start_i = 1'b1; funct3_i = nf3; src_a_i = na; src_b_i = nb;
        end else begin
            @(negedge clk);
            check({tag, "_pulse"}, {30'b0, done_o, busy_o}, 32'd0);
        end
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_res", result_o, 32'd0);
        rst_n = 1'b1;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT); wait_done("mul", 1, 0, 0, 0, 0);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT); wait_done("mulh", 0, 0, 0, 0, 0);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT); wait_done("mulhu", 0, 0, 0, 0, 0);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT); wait_done("mulhsu", 0, 0, 0, 0, 0);
        issue(3'd5, 32'd100, 32'd7, 32'd14, 34); wait_done("divu", 0, 0, 0, 0, 0);
        issue(3'd7, 32'd100, 32'd7, 32'd2, 34); wait_done("remu", 0, 0, 0, 0, 0);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34); wait_done("div_neg", 0, 0, 0, 0, 0);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34); wait_done("rem_neg", 0, 0, 0, 0, 0);
        issue(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2); wait_done("div0", 0, 0, 0, 0, 0);
        issue(3'd6, 32'd5, 32'd0, 32'd5, 2); wait_done("rem0", 0, 0, 0, 0, 0);
        issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2); wait_done("divu0", 0, 0, 0, 0, 0);
        issue(3'd7, 32'd9, 32'd0, 32'd9, 2); wait_done("remu0", 0, 0, 0, 0, 0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2); wait_done("div_ovf", 0, 0, 0, 0, 0);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2); wait_done("rem_ovf", 0, 0, 0, 0, 0);
        issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34); wait_done("divu_big", 0, 0, 0, 0, 0);
        issue(3'd0, 32'h1234_5678, 32'd1, 32'h1234_5678, EARLY_LAT); wait_done("mul_one", 0, 0, 0, 0, 0);

        // Flush mid-CALC: no done, result untouched.
        @(posedge clk); #1; start_i = 1'b1; funct3_i = 3'd0; src_a_i = 32'd3; src_b_i = 32'hFFFF_0000;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_done", 32'(done_o), 32'd0);
        seen = 1'b0;
        repeat (40) begin @(negedge clk); seen |= done_o; end
        check("flush_nodone", 32'(seen), 32'd0);
        check("flush_res", result_o, last_res);

        // Flush and start together: start dropped.
        @(posedge clk); #1; start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd5; src_a_i = 32'd50; src_b_i = 32'd3;
        @(posedge clk); #1; start_i = 1'b0; flush_i = 1'b0;
        check("flush_start_busy", 32'(busy_o), 32'd0);

        // Back-to-back: start held in DONE.
        q_res.push_back(32'hFFFF_FFEB); q_lat.push_back(MUL_LAT);
        @(posedge clk); #1; start_i = 1'b1; funct3_i = 3'd0; src_a_i = 32'd7; src_b_i = 32'hFFFF_FFFD;
        @(posedge clk); #1; start_i = 1'b0;
        wait_done("b2b_1", 0, 1, 3'd5, 32'd100, 32'd7);
        q_res.push_back(32'd14); q_lat.push_back(34);
        @(posedge clk); #1; start_i = 1'b0;
        check("b2b_nogap", 32'(busy_o), 32'd1);
        wait_done("b2b_2", 0, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            issue(f3, a, b, model(f3, a, b), lat_of(f3, a, b));
            wait_done("rand", 0, 0, 0, 0, 0);
        end

        // Asynchronous reset mid-CALC.
        @(posedge clk); #1; start_i = 1'b1; funct3_i = 3'd0; src_a_i = 32'd11; src_b_i = 32'h8000_0001;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0; #1;
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_done", 32'(done_o), 32'd0);
        check("arst_res", result_o, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_idle", {30'b0, done_o, busy_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit for the execute stage of the 5-stage pipelined core. It accepts one operation at a time through a start/busy/done handshake and computes it one bit per cycle (radix-2). While it runs, the hazard unit holds the pipeline off via busy_o. It is parametrised in data width, and the latency behaviour is selectable at build time.

Parameters:
DATA_WIDTH, 32, operand and result width in bits; must be even and at least 8
CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width; derived, not overridden

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous reset, active-low
start_i  in  1  request; sampled only in IDLE or DONE
funct3_i  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a_i  in  DATA_WIDTH  rs1 operand, already forwarded
src_b_i  in  DATA_WIDTH  rs2 operand, already forwarded
flush_i  in  1  abort the in-flight op (branch mispredict or flush)
busy_o  out  1  high whenever state != IDLE and state != DONE
done_o  out  1  one-cycle pulse: result_o valid
result_o  out  DATA_WIDTH  result; held until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, all datapath registers=0, busy_o=0, done_o=0, result_o=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start_i=1 and flush_i=0 → latch the operands and funct3, then either:
  - go to FIX directly (special cases below), or
  - go to CALC with counter=DATA_WIDTH.
- DONE with start_i=0 → IDLE. done_o=1 only in DONE.
- CALC:
  - One iteration per cycle; counter decrements.
  - At counter==1 the next state is FIX.
- FIX:
  - Apply sign correction: negate the product, quotient or remainder as required.
  - Select the high or low half; write result_o.
  - Next state is DONE.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Arithmetic:
  - Operate on absolute values.
  - Multiply uses a 2*DATA_WIDTH product register.
  - MUL returns bits [DATA_WIDTH-1:0]; MULH* return bits [2*DATA_WIDTH-1:DATA_WIDTH].
  - Divide is restoring.
  - Remainder takes the sign of the dividend; quotient is negative iff the operand signs differ and the divisor is nonzero.
- Special cases (skip CALC, go straight to FIX; done_o two cycles after the start edge):
  - Divisor 0: DIV/DIVU → all-ones; REM/REMU → src_a.
  - Signed overflow (src_a = most-negative, src_b = -1): DIV → most-negative; REM → 0.
- Normal latency: done_o high during cycle DATA_WIDTH+2 after the start edge (start edge = cycle 0).
- start_i while busy_o=1 is ignored; the operands are not re-latched.
- flush_i=1 (any state) → IDLE at the next edge, no done_o; result_o keeps its previous value.
- flush_i and start_i in the same cycle → flush wins; the start is dropped.
- Reset mid-operation → immediate IDLE; partial results are discarded.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: for multiply ops, CALC exits to FIX as soon as the remaining unconsumed multiplier bits are all zero. The product is shifted into its final alignment in FIX. Latency is variable: minimum 3 cycles to done_o when |src_b| ≤ 1; results are identical to the undefined case.
- Undefined: every non-special op spends exactly DATA_WIDTH cycles in CALC; latency is fixed.
- Divide latency is unaffected in both cases.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3) → result_o=0xFFFFFFEB, done_o at cycle 34 (macro undefined), busy_o high in cycles 1–33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with done_o at cycle 2; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Start MUL, assert flush_i at cycle 10 → IDLE at cycle 11, no done_o, result_o unchanged. Assert rst_n=0 mid-CALC → all outputs 0 asynchronously.
- Back-to-back: start_i held in DONE → second op accepted with no IDLE gap. With MULDIV_EARLY_OUT_EN, MUL 0x12345678 × 1 → 0x12345678 in ≤3 cycles.
